router_node: RTL and testbench

Parametrised five-port mesh router, the successor to the fixed east/west pass-through node. Each of the local, north, south, east and west inputs has its own FIFO. Flits are routed dimension-ordered (XY) on destination coordinates carried in the flit. Each output has a round-robin arbiter and a registered output stage with valid/ready backpressure. It is the per-tile switch of the 2-D NoC mesh: instances are tied together by the node link wiring and to a local core on port L.

---
 rtl/noc_pkg.sv | 48 ++++
 rtl/router_fifo.sv | 51 +++++
 rtl/router_node.sv | 99 +++++++++
 tb/tb_router_node.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared types and helpers for the 2-D mesh router: flit layout, port indices,
// XY route selection and round-robin pick.
package noc_pkg;

  localparam int FLIT_DATA_W = 8;
  localparam int FLIT_X_W    = 2;
  localparam int FLIT_Y_W    = 2;
  localparam int NPORTS      = 5;

  localparam int P_L = 0;
  localparam int P_N = 1;
  localparam int P_S = 2;
  localparam int P_E = 3;
  localparam int P_W = 4;

  typedef struct packed {
    logic [FLIT_X_W-1:0]    dest_x;
    logic [FLIT_Y_W-1:0]    dest_y;
    logic [FLIT_DATA_W-1:0] data;
  } flit_t;

  // X is resolved before Y, so a flit never turns from a Y link back onto X.
  function automatic logic [2:0] xy_route(flit_t f, logic [FLIT_X_W-1:0] my_x,
                                          logic [FLIT_Y_W-1:0] my_y);
    logic [2:0] port;
    if (f.dest_x > my_x)      port = 3'(P_E);
    else if (f.dest_x < my_x) port = 3'(P_W);
    else if (f.dest_y > my_y) port = 3'(P_N);
    else if (f.dest_y < my_y) port = 3'(P_S);
    else                      port = 3'(P_L);
    return port;
  endfunction

  // Returns {found, index}; scanning backwards lets the first requester
  // at or after ptr overwrite any later one.
  function automatic logic [3:0] rr_pick(logic [NPORTS-1:0] req, logic [2:0] ptr);
    logic [3:0] res;
    int idx;
    res = '0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NPORTS) idx = idx - NPORTS;
      if (req[idx]) res = {1'b1, 3'(idx)};
    end
    return res;
  endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-input flit FIFO; full/empty come from the registered count only,
// so a full FIFO reports full even in a cycle where it pops.
module router_fifo
  import noc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  flit_t                  wr_data,
  input  logic                   pop,
  output flit_t                  rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  flit_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/router_node.sv
// Five-port XY mesh router: per-input FIFOs, per-output round-robin arbiter
// and a registered output stage with valid/ready backpressure.
module router_node
  import noc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int X_W    = 2,
  parameter int Y_W    = 2,
  parameter int DEPTH  = 4,
  parameter int MY_X   = 0,
  parameter int MY_Y   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  flit_t             in_flit   [NPORTS],
  input  logic [NPORTS-1:0] in_valid,
  output logic [NPORTS-1:0] in_ready,
  output flit_t             out_flit  [NPORTS],
  output logic [NPORTS-1:0] out_valid,
  input  logic [NPORTS-1:0] out_ready
);

  localparam int FW = X_W + Y_W + DATA_W;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [X_W-1:0] MY_XC = X_W'(MY_X);
  localparam logic [Y_W-1:0] MY_YC = Y_W'(MY_Y);

  flit_t             head       [NPORTS];
  logic [NPORTS-1:0] fifo_full;
  logic [NPORTS-1:0] fifo_empty;
  logic [NPORTS-1:0] pop;
  logic [CW-1:0]     fifo_count [NPORTS];
  logic [2:0]        dest       [NPORTS];
  logic [NPORTS-1:0] req        [NPORTS];
  logic [3:0]        pick       [NPORTS];
  logic [NPORTS-1:0] gnt_v;
  logic [2:0]        rr         [NPORTS];
  logic [FW-1:0]     out_q      [NPORTS];
  logic              out_v      [NPORTS];

  for (genvar p = 0; p < NPORTS; p++) begin : g_in
    router_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (in_valid[p] & in_ready[p]),
      .wr_data (in_flit[p]),
      .pop     (pop[p]),
      .rd_data (head[p]),
      .full    (fifo_full[p]),
      .empty   (fifo_empty[p]),
      .count   (fifo_count[p])
    );

    assign in_ready[p] = ~fifo_full[p];
    assign dest[p]     = xy_route(head[p], MY_XC, MY_YC);

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
      fifo_count[p] <= CW'(DEPTH));
  end

  always_comb begin
    for (int o = 0; o < NPORTS; o++) begin
      req[o] = '0;
      for (int p = 0; p < NPORTS; p++) begin
        req[o][p] = ~fifo_empty[p] & (dest[p] == 3'(o));
      end
    end
  end

  // Each input requests one output only, so OR-ing the grants never double-pops.
  always_comb begin
    pop = '0;
    for (int o = 0; o < NPORTS; o++) begin
      if (gnt_v[o]) pop[pick[o][2:0]] = 1'b1;
    end
  end

  for (genvar o = 0; o < NPORTS; o++) begin : g_out
    assign pick[o]      = rr_pick(req[o], rr[o]);
    assign gnt_v[o]     = pick[o][3] & (~out_v[o] | out_ready[o]);
    assign out_flit[o]  = out_q[o];
    assign out_valid[o] = out_v[o];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_q[o] <= '0;
        out_v[o] <= 1'b0;
        rr[o]    <= '0;
      end else if (gnt_v[o]) begin
        out_q[o] <= head[pick[o][2:0]];
        out_v[o] <= 1'b1;
        rr[o]    <= (pick[o][2:0] == 3'(NPORTS - 1)) ? 3'd0 : pick[o][2:0] + 3'd1;
      end else if (out_ready[o]) begin
        out_v[o] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_router_node.sv
// Scoreboard bench for router_node at tile (1,1): directed flits with
// hand-picked exit ports, checked by a monitor on every output handshake.
module tb_router_node;
  import noc_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  flit_t             in_flit  [NPORTS];
  logic [NPORTS-1:0] in_valid = '0;
  logic [NPORTS-1:0] in_ready;
  flit_t             out_flit [NPORTS];
  logic [NPORTS-1:0] out_valid;
  logic [NPORTS-1:0] out_ready = '1;

  int    checks = 0;
  int    errors = 0;
  flit_t exp_q     [NPORTS][$];
  flit_t stim_flit [NPORTS];
  int    stim_out  [NPORTS];
  logic [NPORTS-1:0] left;

  always #5 clk = ~clk;

  router_node #(
    .DATA_W (8), .X_W (2), .Y_W (2), .DEPTH (4), .MY_X (1), .MY_Y (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (in_flit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  function automatic flit_t mk_flit(input logic [1:0] x, input logic [1:0] y,
                                    input logic [7:0] d);
    flit_t f;
    f.dest_x = x;
    f.dest_y = y;
    f.data   = d;
    return f;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Holds each masked port valid until accepted; expectations are queued at acceptance.
  task automatic apply_stimulus(input logic [NPORTS-1:0] mask, input int budget,
                                output logic [NPORTS-1:0] pending);
    logic [NPORTS-1:0] pend;
    pend = mask;
    for (int p = 0; p < NPORTS; p++) if (mask[p]) in_flit[p] = stim_flit[p];
    for (int c = 0; c < budget && pend != '0; c++) begin
      in_valid = pend;
      for (int p = 0; p < NPORTS; p++) begin
        if (pend[p] && in_ready[p]) begin
          exp_q[stim_out[p]].push_back(stim_flit[p]);
          pend[p] = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    in_valid = '0;
    pending  = pend;
  endtask

  task automatic clear_queues();
    for (int o = 0; o < NPORTS; o++) exp_q[o].delete();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '1;
    clear_queues();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_output("reset_out_valid", 32'(out_valid), 32'h0);
    check_output("reset_in_ready", 32'(in_ready), 32'h1f);
    check_output("reset_out_flit_e", 32'(out_flit[P_E]), 32'h0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int o = 0; o < NPORTS; o++) begin
        if (out_valid[o] && out_ready[o]) begin
          checks++;
          if (exp_q[o].size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_out[%0d]: got %0h expected none", o, out_flit[o]);
          end else begin
            flit_t e;
            e = exp_q[o].pop_front();
            if (out_flit[o] !== e) begin
              errors++;
              $display("[TB] FAIL out_flit[%0d]: got %0h expected %0h", o, out_flit[o], e);
            end
          end
        end
      end
    end
  end

  initial begin
    for (int p = 0; p < NPORTS; p++) begin
      in_flit[p]   = '0;
      stim_flit[p] = '0;
      stim_out[p]  = 0;
    end

    // Local delivery and two-cycle latency
    do_reset();
    stim_flit[P_L] = mk_flit(2'd1, 2'd1, 8'h5A);
    stim_out[P_L]  = P_L;
    apply_stimulus(5'b00001, 8, left);
    check_output("local_accept", 32'(left), 32'h0);
    check_output("local_lat_t", 32'(out_valid), 32'h0);
    wait_cycles(1);
    check_output("local_lat_t1", 32'(out_valid), 32'h01);
    check_output("local_data", 32'(out_flit[P_L].data), 32'h5A);
    wait_cycles(1);
    check_output("local_cleared", 32'(out_valid), 32'h0);

    // XY order: X resolved before Y
    do_reset();
    stim_flit[P_W] = mk_flit(2'd3, 2'd0, 8'h11);
    stim_out[P_W]  = P_E;
    stim_flit[P_N] = mk_flit(2'd1, 2'd0, 8'h22);
    stim_out[P_N]  = P_S;
    apply_stimulus(5'b10010, 8, left);
    check_output("xy_accept", 32'(left), 32'h0);
    wait_cycles(1);
    check_output("xy_out_valid", 32'(out_valid), 32'h0c);
    wait_cycles(3);
    check_output("xy_drained", 32'(exp_q[P_E].size() + exp_q[P_S].size()), 32'h0);

    // Round-robin among N, S, W all targeting E
    do_reset();
    for (int r = 0; r < 3; r++) begin
      stim_flit[P_N] = mk_flit(2'd2, 2'd1, 8'h10 + 8'(r));
      stim_flit[P_S] = mk_flit(2'd2, 2'd2, 8'h20 + 8'(r));
      stim_flit[P_W] = mk_flit(2'd3, 2'd0, 8'h40 + 8'(r));
      stim_out[P_N]  = P_E;
      stim_out[P_S]  = P_E;
      stim_out[P_W]  = P_E;
      apply_stimulus(5'b10110, 8, left);
      check_output("rr_accept", 32'(left), 32'h0);
    end
    wait_cycles(12);
    check_output("rr_drained", 32'(exp_q[P_E].size()), 32'h0);

    // Backpressure: one flit in the output register, four in the W FIFO
    do_reset();
    out_ready = 5'b10111;
    for (int i = 0; i < 5; i++) begin
      stim_flit[P_W] = mk_flit(2'd3, 2'd1, 8'h60 + 8'(i));
      stim_out[P_W]  = P_E;
      apply_stimulus(5'b10000, 4, left);
      check_output("bp_accept", 32'(left), 32'h0);
    end
    stim_flit[P_W] = mk_flit(2'd3, 2'd1, 8'h65);
    apply_stimulus(5'b10000, 3, left);
    check_output("bp_sixth_rejected", 32'(left), 32'h10);
    check_output("bp_in_ready_w", 32'(in_ready[P_W]), 32'h0);
    check_output("bp_out_valid_e", 32'(out_valid[P_E]), 32'h1);
    check_output("bp_out_flit_e", 32'(out_flit[P_E]), 32'(mk_flit(2'd3, 2'd1, 8'h60)));
    wait_cycles(2);
    check_output("bp_hold", 32'(out_flit[P_E]), 32'(mk_flit(2'd3, 2'd1, 8'h60)));
    out_ready = '1;
    wait_cycles(10);
    check_output("bp_drained", 32'(exp_q[P_E].size()), 32'h0);
    check_output("bp_in_ready_after", 32'(in_ready[P_W]), 32'h1);

    // Reset mid-traffic discards everything at once
    do_reset();
    out_ready = 5'b00000;
    for (int i = 0; i < 3; i++) begin
      stim_flit[P_L] = mk_flit(2'd2, 2'd1, 8'h70 + 8'(i));
      stim_out[P_L]  = P_E;
      apply_stimulus(5'b00001, 4, left);
      check_output("rst_accept", 32'(left), 32'h0);
    end
    check_output("rst_pre_valid", 32'(out_valid[P_E]), 32'h1);
    rst = 1'b1;
    #1;
    check_output("rst_async_valid", 32'(out_valid), 32'h0);
    clear_queues();
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = '1;
    check_output("rst_in_ready", 32'(in_ready), 32'h1f);
    wait_cycles(8);
    check_output("rst_no_stale", 32'(out_valid), 32'h0);

    for (int o = 0; o < NPORTS; o++) begin
      check_output("final_queue_empty", 32'(exp_q[o].size()), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
